ctrl_seq: RTL
=============

// Module: ctrl_seq
// PURPOSE
//  Parametrised control sequencer for the simple-viii core: fetches an opcode, optionally one
//  operand word, then drives memory, address-register, ALU, register-file and bus-mux controls.
//  Generalises the 8-bit control unit in data width, register-select width and ALU-op width.
//  Adds a memory-handshake timeout, a sticky FAULT state, a HALT opcode and a retire pulse.
//  Sits between the memory controller / address register and the ALU / register-file datapath.
// PARAMETERS
//  DATA_BUS_WIDTH  8  width of the opcode and operand word on bus_data_in
//  REG_SEL_W       2  register-select width; requires 2+ALU_OP_W+2*REG_SEL_W <= DATA_BUS_WIDTH
//  ALU_OP_W        2  ALU operation field width
//  MEM_TIMEOUT     15 cycles a memory op may wait for mem_op_done before FAULT; 0 = no timeout
// PORTS
//  clock        in   1         rising-edge clock
//  reset        in   1         asynchronous, active-high reset
//  bus_data_in  in   DATA_BUS_WIDTH  read data; valid in the cycle mem_op_done=1
//  mem_op_done  in   1         memory controller completed the current mem_op
//  alu_flags    in   4         {N,C,V,Z}; registered for debug only, no control effect
//  mem_op       out  2         00 idle, 01 read, 10 write (11 never driven)
//  addr_sel     out  1         0 = PC drives address, 1 = address register
//  pc_inc       out  1         one-cycle pulse: PC += 1
//  addr_load    out  1         one-cycle pulse: address register <= bus_data_in
//  alu_op       out  ALU_OP_W  ALU operation
//  reg_we       out  1         register-file write enable (one cycle)
//  reg_sel_in   out  REG_SEL_W write-port select
//  reg_sel_1    out  REG_SEL_W read-port 1 select (also store-data source)
//  reg_sel_2    out  REG_SEL_W read-port 2 select
//  mux_sel      out  1         register write source: 0 = ALU, 1 = bus
//  retire       out  1         one-cycle pulse when an instruction completes
//  halted       out  1         high while in HALT
//  fault        out  1         high while in FAULT (sticky until reset)
// BEHAVIOUR
//  Reset: state FETCH, IR=0, timeout counter 0. All outputs 0 except mem_op=01 from the first
//   cycle after reset release (FETCH drives a read).
//  Opcode fields, W=DATA_BUS_WIDTH, R=REG_SEL_W, A=ALU_OP_W:
//   cls = IR[W-1:W-2]; aop = IR[W-3:W-2-A]; rA = IR[2R-1:R]; rB = IR[R-1:0].
//   Store bit = IR[W-3]; it applies to class 10 only.
//  States and transitions (one edge each unless noted):
//   FETCH: mem_op=01, addr_sel=0. Holds until mem_op_done. On that edge: IR<=bus_data_in,
//    pc_inc=1 in that cycle, next DECODE.
//   DECODE: one cycle with no control outputs. Next state by cls:
//    00 -> EXEC_ALU; 01 and 10 -> OPERAND.
//    11 with IR all-ones -> HALT. 11 otherwise (NOP) -> FETCH with retire=1.
//   EXEC_ALU: one cycle. Drives alu_op=aop, reg_sel_1=rA, reg_sel_2=rB, reg_sel_in=rA,
//    mux_sel=0, reg_we=1, retire=1. Next FETCH.
//   OPERAND: mem_op=01, addr_sel=0. In the done cycle pc_inc=1, then:
//    cls 01 (load immediate): reg_sel_in=rA, mux_sel=1, reg_we=1, retire=1 -> FETCH.
//    cls 10: addr_load=1 -> EXEC_MEM.
//   EXEC_MEM: addr_sel=1. Store bit 0: mem_op=01. Store bit 1: mem_op=10 with reg_sel_1=rA.
//    In the done cycle: a load also drives reg_sel_in=rA, mux_sel=1, reg_we=1.
//    Both load and store drive retire=1 -> FETCH.
//   HALT: all controls 0, halted=1, terminal until reset.
//   FAULT: all controls 0, fault=1, terminal until reset.
//  Handshake: mem_op stays stable from state entry until the cycle mem_op_done=1 inclusive.
//   A done in the first cycle is legal (zero wait). mem_op_done is ignored when mem_op=00.
//  Timeout: the counter clears on entry to each memory state and increments each waiting
//   cycle without done. When it reaches MEM_TIMEOUT with done still low -> FAULT next edge.
//   Done in the same cycle as the limit wins: the op completes normally.
//  Reset mid-instruction: immediate return to reset state. No partial writes; reg_we drops.
// TESTING
//  1 Reset release, opcode 8'h00 with 0-wait done -> FETCH(1), DECODE(1), EXEC_ALU with
//    alu_op=0, reg_we=1, retire=1; next cycle mem_op=01.
//  2 Opcode 8'b01_00_10_00, operand 8'h5A, 3 wait cycles each -> reg_sel_in=2, mux_sel=1,
//    reg_we=1 in the operand-done cycle; pc_inc pulsed twice in total.
//  3 Store 8'b10_1_0_01_00, operand 8'h80 -> addr_load=1, then EXEC_MEM mem_op=10, addr_sel=1,
//    reg_sel_1=1. Load variant 8'b10_0_0_01_00 -> reg_we=1, mux_sel=1.
//  4 Opcode 8'hFF -> halted=1 and mem_op=00 held for 20 cycles; then reset -> FETCH.
//  5 FETCH with done never asserted -> fault=1 after 15 wait cycles. done arriving exactly
//    at cycle 15 -> no fault.
//  6 Assert reset during EXEC_MEM wait -> all outputs 0 that cycle; FETCH resumes on release.
//    Repeat tests 1-3 with DATA_BUS_WIDTH=16, REG_SEL_W=3.

Source files
------------

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the simple-viii core.
// Fetches an opcode, optionally one operand word, then drives memory,
// address-register, ALU, register-file and bus-mux controls. Every memory
// wait is bounded by a timeout that parks the sequencer in a sticky FAULT.
module ctrl_seq #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int REG_SEL_W      = 2,
    parameter int ALU_OP_W       = 2,
    parameter int MEM_TIMEOUT    = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
    input  logic                      mem_op_done,
    input  logic [3:0]                alu_flags,
    output logic [1:0]                mem_op,
    output logic                      addr_sel,
    output logic                      pc_inc,
    output logic                      addr_load,
    output logic [ALU_OP_W-1:0]       alu_op,
    output logic                      reg_we,
    output logic [REG_SEL_W-1:0]      reg_sel_in,
    output logic [REG_SEL_W-1:0]      reg_sel_1,
    output logic [REG_SEL_W-1:0]      reg_sel_2,
    output logic                      mux_sel,
    output logic                      retire,
    output logic                      halted,
    output logic                      fault
);
    localparam int W     = DATA_BUS_WIDTH;
    localparam int R     = REG_SEL_W;
    localparam int A     = ALU_OP_W;
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MEM_TIMEOUT);

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC_ALU, S_OPERAND, S_EXEC_MEM, S_HALT, S_FAULT
    } state_t;

    state_t           r_state, w_next;
    logic [W-1:0]     r_ir;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_flags;

    // Opcode fields
    logic [1:0]   w_cls;
    logic [A-1:0] w_aop;
    logic [R-1:0] w_ra, w_rb;
    logic         w_store, w_all_ones, w_mem_state, w_timeout, w_unused;

    assign w_cls      = r_ir[W-1 -: 2];
    assign w_aop      = r_ir[W-3 -: A];
    assign w_ra       = r_ir[2*R-1 -: R];
    assign w_rb       = r_ir[R-1:0];
    assign w_store    = r_ir[W-3];
    assign w_all_ones = &r_ir;
    // Flags are captured for debug visibility only; gaps in wide opcodes are spare.
    assign w_unused   = ^{r_flags, r_ir};

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_OPERAND) ||
                         (r_state == S_EXEC_MEM);
    // Done at the limit cycle still wins, so the timeout requires done low.
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !mem_op_done &&
                         (r_cnt == CNT_LIM);

    // State, instruction register, wait counter and debug flag capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            r_flags <= alu_flags;
            if (r_state == S_FETCH && mem_op_done)
                r_ir <= bus_data_in;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (MEM_TIMEOUT != 0 && w_mem_state && !mem_op_done)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next state and control outputs; reset forces every control low
    always_comb begin
        w_next     = r_state;
        mem_op     = MEM_IDLE;
        addr_sel   = 1'b0;
        pc_inc     = 1'b0;
        addr_load  = 1'b0;
        alu_op     = '0;
        reg_we     = 1'b0;
        reg_sel_in = '0;
        reg_sel_1  = '0;
        reg_sel_2  = '0;
        mux_sel    = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_op = MEM_READ;
                    if (mem_op_done) begin
                        pc_inc = 1'b1;
                        w_next = S_DECODE;
                    end else if (w_timeout) begin
                        w_next = S_FAULT;
                    end
                end
                S_DECODE: begin
                    case (w_cls)
                        2'b00:   w_next = S_EXEC_ALU;
                        2'b01,
                        2'b10:   w_next = S_OPERAND;
                        default: begin
                            if (w_all_ones) begin
                                w_next = S_HALT;
                            end else begin
                                retire = 1'b1;
                                w_next = S_FETCH;
                            end
                        end
                    endcase
                end
                S_EXEC_ALU: begin
                    alu_op     = w_aop;
                    reg_sel_1  = w_ra;
                    reg_sel_2  = w_rb;
                    reg_sel_in = w_ra;
                    reg_we     = 1'b1;
                    retire     = 1'b1;
                    w_next     = S_FETCH;
                end
                S_OPERAND: begin
                    mem_op = MEM_READ;
                    if (mem_op_done) begin
                        pc_inc = 1'b1;
                        if (w_cls == 2'b01) begin
                            reg_sel_in = w_ra;
                            mux_sel    = 1'b1;
                            reg_we     = 1'b1;
                            retire     = 1'b1;
                            w_next     = S_FETCH;
                        end else begin
                            addr_load = 1'b1;
                            w_next    = S_EXEC_MEM;
                        end
                    end else if (w_timeout) begin
                        w_next = S_FAULT;
                    end
                end
                S_EXEC_MEM: begin
                    addr_sel = 1'b1;
                    if (w_store) begin
                        mem_op    = MEM_WRITE;
                        reg_sel_1 = w_ra;
                    end else begin
                        mem_op = MEM_READ;
                    end
                    if (mem_op_done) begin
                        if (!w_store) begin
                            reg_sel_in = w_ra;
                            mux_sel    = 1'b1;
                            reg_we     = 1'b1;
                        end
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end else if (w_timeout) begin
                        w_next = S_FAULT;
                    end
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: w_next = S_FETCH;
            endcase
        end
    end
endmodule
